// File: rtl/copro_result_buffer_pkg.sv
// Shared definitions for the coprocessor result buffer and its FIFO.
// Optional feature macro: COPRO_RESULT_BYPASS_EN (see copro_result_buffer.sv).
package copro_result_buffer_pkg;

    // Width of the destination register index carried with every result.
    localparam int unsigned RegAddrWidth = 5;

    // Per-cycle FIFO operation, encoded as {push, pop}.
    typedef enum logic [1:0] {
        OpIdle = 2'b00,
        OpPop  = 2'b01,
        OpPush = 2'b10,
        OpBoth = 2'b11
    } fifo_op_e;

    // Width of a counter that must hold every value from 0 up to depth inclusive.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/copro_result_fifo.sv
// Generic circular-buffer FIFO: power-of-two depth, wrapping pointers,
// an explicit occupancy counter and full/empty flags. The caller qualifies
// push and pop; this block never refuses a request it is given.
module copro_result_fifo
    import copro_result_buffer_pkg::*;
#(
    parameter int unsigned Width = 32,
    parameter int unsigned Depth = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    push_i,
    input  logic [Width-1:0]        data_i,
    input  logic                    pop_i,
    output logic [Width-1:0]        data_o,
    output logic                    full_o,
    output logic                    empty_o,
    output logic [$clog2(Depth):0]  count_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam logic [PtrW:0] FullCount = (PtrW + 1)'(Depth);

    logic [Width-1:0] mem [Depth];
    logic [PtrW-1:0]  wr_ptr;
    logic [PtrW-1:0]  rd_ptr;
    logic [PtrW:0]    count;
    fifo_op_e         op;

    assign op = fifo_op_e'({push_i, pop_i});

    // Storage array; data needs no reset because the count gates its use.
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem[wr_ptr] <= data_i;
        end
    end

    // Pointers advance independently and wrap naturally at the power-of-two depth.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_i) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_i) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Occupancy follows the combined operation; push plus pop leaves it unchanged.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count <= '0;
        end else begin
            case (op)
                OpPush:  count <= count + 1'b1;
                OpPop:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign data_o  = mem[rd_ptr];
    assign full_o  = (count == FullCount);
    assign empty_o = (count == '0);
    assign count_o = count;

endmodule

// File: rtl/copro_result_buffer.sv
// Result buffer between the non-stalling coprocessor ALU and the CV-X-IF
// result interface. Results are queued in a small FIFO and offered through
// valid/ready; an in-flight counter plus occupancy gates issue so the ALU
// never produces a result without a slot for it. A result arriving while
// the FIFO is full and not draining is dropped and latches a sticky overflow.
// Optional feature macro: COPRO_RESULT_BYPASS_EN -- when defined, a result
// arriving at an empty FIFO is presented combinationally in the same cycle.
module copro_result_buffer
    import copro_result_buffer_pkg::*;
#(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned Depth    = 4,
    parameter type         hartid_t = logic,
    parameter type         id_t     = logic
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    issue_fire_i,
    output logic                    issue_ready_o,
    input  logic                    alu_valid_i,
    input  logic [XLEN-1:0]         alu_result_i,
    input  hartid_t                 alu_hartid_i,
    input  id_t                     alu_id_i,
    input  logic [RegAddrWidth-1:0] alu_rd_i,
    input  logic                    alu_we_i,
    output logic                    result_valid_o,
    input  logic                    result_ready_i,
    output logic [XLEN-1:0]         result_data_o,
    output hartid_t                 result_hartid_o,
    output id_t                     result_id_o,
    output logic [RegAddrWidth-1:0] result_rd_o,
    output logic                    result_we_o,
    output logic                    overflow_o
);

    localparam int unsigned CntW = cnt_width(Depth);
    localparam logic [CntW:0] CreditLimit = (CntW + 1)'(Depth);

    typedef struct packed {
        logic [XLEN-1:0]         data;
        hartid_t                 hartid;
        id_t                     id;
        logic [RegAddrWidth-1:0] rd;
        logic                    we;
    } copro_result_t;

    copro_result_t   alu_entry;
    copro_result_t   fifo_head;
    copro_result_t   head_sel;
    copro_result_t   out_entry;
    logic            fifo_push;
    logic            fifo_pop;
    logic            fifo_full;
    logic            fifo_empty;
    logic [CntW-1:0] occupancy;
    logic [CntW-1:0] inflight;
    logic [CntW:0]   credit_sum;
    logic            overflow_q;

    assign alu_entry = '{
        data:   alu_result_i,
        hartid: alu_hartid_i,
        id:     alu_id_i,
        rd:     alu_rd_i,
        we:     alu_we_i
    };

    copro_result_fifo #(
        .Width ($bits(copro_result_t)),
        .Depth (Depth)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (fifo_push),
        .data_i  (alu_entry),
        .pop_i   (fifo_pop),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (occupancy)
    );

`ifdef COPRO_RESULT_BYPASS_EN
    logic bypass_active;

    // An empty FIFO hands a fresh ALU result straight to the core; it is
    // stored only if the core does not take it this cycle.
    assign bypass_active  = fifo_empty && alu_valid_i;
    assign result_valid_o = !fifo_empty || bypass_active;
    assign head_sel       = fifo_empty ? alu_entry : fifo_head;
    assign fifo_pop       = !fifo_empty && result_ready_i;
    assign fifo_push      = alu_valid_i && (!fifo_full || fifo_pop)
                            && !(bypass_active && result_ready_i);
`else
    // Every result passes through storage, so outputs depend only on registers.
    assign result_valid_o = !fifo_empty;
    assign head_sel       = fifo_head;
    assign fifo_pop       = result_valid_o && result_ready_i;
    assign fifo_push      = alu_valid_i && (!fifo_full || fifo_pop);
`endif

    // Count instructions issued to the ALU whose results have not yet appeared.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            inflight <= '0;
        end else if (issue_fire_i && !alu_valid_i) begin
            inflight <= inflight + 1'b1;
        end else if (!issue_fire_i && alu_valid_i) begin
            inflight <= inflight - 1'b1;
        end
    end

    // A dropped result is a protocol violation; remember it until reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            overflow_q <= 1'b0;
        end else if (alu_valid_i && fifo_full && !fifo_pop) begin
            overflow_q <= 1'b1;
        end
    end

    // Sum at one extra bit so a full FIFO plus outstanding work cannot wrap.
    assign credit_sum    = {1'b0, occupancy} + {1'b0, inflight};
    assign issue_ready_o = (credit_sum < CreditLimit);
    assign overflow_o    = overflow_q;

    // Drive result fields only while a result is offered; zero otherwise.
    always_comb begin
        out_entry = '0;
        if (result_valid_o) begin
            out_entry = head_sel;
        end
    end

    assign result_data_o   = out_entry.data;
    assign result_hartid_o = out_entry.hartid;
    assign result_id_o     = out_entry.id;
    assign result_rd_o     = out_entry.rd;
    assign result_we_o     = out_entry.we;

endmodule

// File: tb/tb_copro_result_buffer.sv
// Self-checking bench for copro_result_buffer. The stimulus side keeps a
// behavioural model (stored-result count, outstanding issues, sticky error)
// and queues every result that should eventually reach the core; a monitor
// pops that queue on each handshake and compares. Honours
// COPRO_RESULT_BYPASS_EN when the build defines it.
module tb_copro_result_buffer;

    localparam int unsigned Xlen  = 32;
    localparam int unsigned Depth = 4;
`ifdef COPRO_RESULT_BYPASS_EN
    localparam bit Bypass = 1'b1;
`else
    localparam bit Bypass = 1'b0;
`endif

    typedef logic [1:0] hart_t;
    typedef logic [3:0] tag_t;

    typedef struct packed {
        logic [Xlen-1:0] data;
        hart_t           hartid;
        tag_t            id;
        logic [4:0]      rd;
        logic            we;
    } res_t;

    logic            clk_i = 1'b0;
    logic            rst_ni = 1'b1;
    logic            issue_fire_i = 1'b0;
    logic            issue_ready_o;
    logic            alu_valid_i = 1'b0;
    logic [Xlen-1:0] alu_result_i = '0;
    hart_t           alu_hartid_i = '0;
    tag_t            alu_id_i = '0;
    logic [4:0]      alu_rd_i = '0;
    logic            alu_we_i = 1'b0;
    logic            result_valid_o;
    logic            result_ready_i = 1'b0;
    logic [Xlen-1:0] result_data_o;
    hart_t           result_hartid_o;
    tag_t            result_id_o;
    logic [4:0]      result_rd_o;
    logic            result_we_o;
    logic            overflow_o;

    res_t exp_q[$];
    int   tests_run = 0;
    int   tests_failed = 0;
    int   model_count = 0;
    int   model_inflight = 0;
    bit   model_overflow = 1'b0;
    bit   credit_known = 1'b1;

    copro_result_buffer #(
        .XLEN     (Xlen),
        .Depth    (Depth),
        .hartid_t (hart_t),
        .id_t     (tag_t)
    ) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .issue_fire_i    (issue_fire_i),
        .issue_ready_o   (issue_ready_o),
        .alu_valid_i     (alu_valid_i),
        .alu_result_i    (alu_result_i),
        .alu_hartid_i    (alu_hartid_i),
        .alu_id_i        (alu_id_i),
        .alu_rd_i        (alu_rd_i),
        .alu_we_i        (alu_we_i),
        .result_valid_o  (result_valid_o),
        .result_ready_i  (result_ready_i),
        .result_data_o   (result_data_o),
        .result_hartid_o (result_hartid_o),
        .result_id_o     (result_id_o),
        .result_rd_o     (result_rd_o),
        .result_we_o     (result_we_o),
        .overflow_o      (overflow_o)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk_i = ~clk_i;

    task automatic compareValue(input string name, input logic [63:0] actual,
                                input logic [63:0] required);
        tests_run++;
        if (actual !== required) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, required);
        end
    endtask

    function automatic res_t observed();
        return res_t'({result_data_o, result_hartid_o, result_id_o, result_rd_o, result_we_o});
    endfunction

    // Compare the control outputs and the offered head against the model.
    task automatic checkOutput(input bit exp_valid);
        compareValue("result_valid", 64'(result_valid_o), 64'(exp_valid));
        if (credit_known) begin
            compareValue("issue_ready", 64'(issue_ready_o),
                         64'((model_count + model_inflight) < int'(Depth)));
        end
        compareValue("overflow", 64'(overflow_o), 64'(model_overflow));
        if (result_valid_o) begin
            if (exp_q.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("[TB] FAIL head_present: got valid result, expected none queued");
            end else begin
                compareValue("head_fields", 64'(observed()), 64'(exp_q[0]));
            end
        end else begin
            compareValue("idle_fields_zero", 64'(observed()), 64'(0));
        end
    endtask

    // Drive one cycle of inputs, predict the outputs, then advance the model.
    task automatic applyStimulus(input bit issue, input bit alu, input logic [Xlen-1:0] data,
                                 input hart_t hart, input tag_t id, input logic [4:0] rd,
                                 input bit we, input bit ready);
        bit   exp_valid;
        bit   drop;
        bit   passthrough;
        bit   store_pop;
        res_t item;
        @(posedge clk_i);
        #1;
        issue_fire_i   = issue;
        alu_valid_i    = alu;
        alu_result_i   = data;
        alu_hartid_i   = hart;
        alu_id_i       = id;
        alu_rd_i       = rd;
        alu_we_i       = we;
        result_ready_i = ready;
        if (alu && model_inflight <= 0) begin
            credit_known = 1'b0;
        end
        item        = '{data: data, hartid: hart, id: id, rd: rd, we: we};
        exp_valid   = (model_count > 0) || (Bypass && alu);
        passthrough = Bypass && alu && (model_count == 0) && ready;
        store_pop   = (model_count > 0) && ready;
        drop        = alu && (model_count == int'(Depth)) && !store_pop;
        if (alu && !drop) begin
            exp_q.push_back(item);
        end
        #2;
        checkOutput(exp_valid);
        if (drop) begin
            model_overflow = 1'b1;
        end
        model_count    = model_count + ((alu && !drop && !passthrough) ? 1 : 0)
                         - (store_pop ? 1 : 0);
        model_inflight = model_inflight + (issue ? 1 : 0) - (alu ? 1 : 0);
    endtask

    task automatic idleCycles(input int n, input bit ready);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, 1'b0, '0, '0, '0, '0, 1'b0, ready);
        end
    endtask

    // Assert reset mid-operation, confirm the asynchronous clear, clear the model.
    task automatic doReset();
        @(posedge clk_i);
        #1;
        rst_ni = 1'b0;
        issue_fire_i = 1'b0;
        alu_valid_i = 1'b0;
        result_ready_i = 1'b0;
        #1;
        compareValue("reset_valid", 64'(result_valid_o), 64'(0));
        compareValue("reset_ready", 64'(issue_ready_o), 64'(1));
        compareValue("reset_overflow", 64'(overflow_o), 64'(0));
        compareValue("reset_fields", 64'(observed()), 64'(0));
        exp_q.delete();
        model_count = 0;
        model_inflight = 0;
        model_overflow = 1'b0;
        credit_known = 1'b1;
        @(posedge clk_i);
        #2;
        rst_ni = 1'b1;
    endtask

    // Issue Depth instructions and return Depth results with the core stalled.
    task automatic fillFifo();
        for (int i = 0; i < int'(Depth); i++) begin
            applyStimulus(1'b1, 1'b0, '0, '0, '0, '0, 1'b0, 1'b0);
        end
        for (int i = 0; i < int'(Depth); i++) begin
            applyStimulus(1'b0, 1'b1, $urandom, hart_t'(i), tag_t'(i), 5'(i + 1), 1'b1, 1'b0);
        end
    endtask

    // Scoreboard monitor: every accepted result must match the oldest expected one.
    initial begin
        forever begin
            @(negedge clk_i);
            if (rst_ni && result_valid_o && result_ready_i) begin
                if (exp_q.size() == 0) begin
                    tests_run++;
                    tests_failed++;
                    $display("[TB] FAIL popped_result: got id %0h, expected no result", result_id_o);
                end else begin
                    compareValue("popped_result", 64'(observed()), 64'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        bit iss;
        bit alu;
        bit rdy;

        doReset();

        // Single result with the core ready.
        applyStimulus(1'b1, 1'b0, '0, '0, '0, '0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1, 32'h0000_0011, 2'd1, 4'd2, 5'd5, 1'b1, 1'b1);
        idleCycles(3, 1'b1);

        // Backpressure: fill, observe credit exhaustion, drain in order.
        fillFifo();
        idleCycles(2, 1'b0);
        idleCycles(6, 1'b1);

        // Full FIFO with a same-cycle push and pop.
        fillFifo();
        applyStimulus(1'b0, 1'b1, 32'hCAFE_0009, 2'd3, 4'd9, 5'd9, 1'b0, 1'b1);
        idleCycles(6, 1'b1);
        doReset();

        // Overflow: the extra result is dropped and the flag sticks until reset.
        fillFifo();
        applyStimulus(1'b0, 1'b1, 32'hDEAD_0007, 2'd0, 4'd7, 5'd7, 1'b1, 1'b0);
        idleCycles(3, 1'b0);
        idleCycles(6, 1'b1);
        compareValue("overflow_drained", 64'(exp_q.size()), 64'(0));
        doReset();

        // Result arriving at an empty FIFO with the core ready.
        applyStimulus(1'b1, 1'b0, '0, '0, '0, '0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1, 32'h0000_00A5, 2'd2, 4'd5, 5'd3, 1'b1, 1'b1);
        idleCycles(2, 1'b1);

        // Randomized traffic that respects the credit protocol.
        for (int c = 0; c < 600; c++) begin
            iss = ((model_count + model_inflight) < int'(Depth)) && ($urandom_range(0, 1) == 1);
            alu = (model_inflight > 0) && ($urandom_range(0, 2) != 0);
            rdy = ($urandom_range(0, 9) < 6);
            applyStimulus(iss, alu, $urandom, hart_t'($urandom), tag_t'($urandom),
                          5'($urandom), 1'($urandom), rdy);
        end
        while (model_inflight > 0) begin
            applyStimulus(1'b0, 1'b1, $urandom, hart_t'($urandom), tag_t'($urandom),
                          5'($urandom), 1'($urandom), 1'b1);
        end
        idleCycles(Depth + 2, 1'b1);
        compareValue("random_drained", 64'(exp_q.size()), 64'(0));

        // Reset in the middle of buffered traffic.
        fillFifo();
        doReset();
        idleCycles(2, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
